// File: rtl/spmp_seq_checker.sv
// Sequential S-mode PMP checker: one shared address matcher walks the
// entries in ascending order, one per cycle; the lowest matching index wins.

package riscv;
    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        TOR   = 2'b01,
        NA4   = 2'b10,
        NAPOT = 2'b11
    } pmp_addr_mode_t;

    typedef logic [53:0] spmpaddr_t;
endpackage

module spmp_entry
    import riscv::*;
#(
    parameter int unsigned PLEN = 56
) (
    input  logic [PLEN-1:0] addr,
    input  logic [PLEN-3:0] spmpaddr,
    input  logic [PLEN-3:0] prev,
    input  pmp_addr_mode_t  mode,
    output logic            match
);
    logic [PLEN-3:0] word;
    logic [PLEN-3:0] napot_care;

    assign word = addr[PLEN-1:2];
    // Trailing ones of spmpaddr plus the bit above them are "don't care".
    assign napot_care = ~(spmpaddr ^ (spmpaddr + (PLEN-2)'(1)));

    always_comb begin
        match = 1'b0;
        unique case (mode)
            OFF:   match = 1'b0;
            TOR:   match = (word >= prev) && (word < spmpaddr);
            NA4:   match = (word == spmpaddr);
            NAPOT: match = ((word ^ spmpaddr) & napot_care) == '0;
            default: match = 1'b0;
        endcase
    end
endmodule

module spmp_seq_checker
    import riscv::*;
#(
    parameter int unsigned PLEN       = 56,
    parameter int unsigned NR_ENTRIES = 16,
    parameter int unsigned IDXW       = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [PLEN-1:0]                 req_addr_i,
    input  logic [2:0]                      req_access_i,
    input  priv_lvl_t                       priv_lvl_i,
    input  logic                            sum_i,
    input  logic [NR_ENTRIES-1:0][7:0]      spmpcfg_i,
    input  spmpaddr_t [NR_ENTRIES-1:0]      spmpaddr_i,
    output logic                            resp_valid_o,
    input  logic                            resp_ready_i,
    output logic                            resp_allow_o,
    output logic                            resp_match_o,
    output logic [IDXW-1:0]                 resp_idx_o,
    output logic                            busy_o
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        RESP = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [PLEN-1:0] addr_q, addr_d;
    logic [2:0]      acc_q, acc_d;
    priv_lvl_t       priv_q, priv_d;
    logic            sum_q, sum_d;
    logic            match_q, match_d;
    logic [IDXW-1:0] ridx_q, ridx_d;
    logic            allow_q, allow_d;

    logic [7:0]      cfg_cur;
    logic [PLEN-3:0] cur_addr;
    logic [PLEN-3:0] prev_addr;
    logic            hit;
    logic            last;
    logic            base_ok;
    logic            perm_ok;
    logic            is_u;
    logic            unused_cfg;

    assign cfg_cur    = spmpcfg_i[idx_q];
    assign cur_addr   = spmpaddr_i[idx_q][PLEN-3:0];
    assign prev_addr  = (idx_q == '0) ? '0
                      : spmpaddr_i[idx_q - IDXW'(1)][PLEN-3:0];
    assign last       = (idx_q == IDXW'(NR_ENTRIES - 1));
    assign unused_cfg = ^cfg_cur[6:5];

    spmp_entry #(
        .PLEN (PLEN)
    ) u_entry (
        .addr     (addr_q),
        .spmpaddr (cur_addr),
        .prev     (prev_addr),
        .mode     (pmp_addr_mode_t'(cfg_cur[4:3])),
        .match    (hit)
    );

    assign is_u    = (priv_q == PRIV_LVL_U);
    assign base_ok = |(acc_q & cfg_cur[2:0]);

    // U-flagged entries are user memory: S may only touch them as data under SUM.
    always_comb begin
        perm_ok = 1'b0;
        unique case (1'b1)
            is_u:                 perm_ok = base_ok & cfg_cur[7];
            !is_u && !cfg_cur[7]: perm_ok = base_ok;
            default:              perm_ok = base_ok & sum_q & ~acc_q[2];
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        priv_d  = priv_q;
        sum_d   = sum_q;
        match_d = match_q;
        ridx_d  = ridx_q;
        allow_d = allow_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_d  = req_addr_i;
                        acc_d   = req_access_i;
                        priv_d  = priv_lvl_i;
                        sum_d   = sum_i;
                        idx_d   = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        match_d = 1'b1;
                        ridx_d  = idx_q;
                        allow_d = perm_ok;
                        state_d = RESP;
                    end else if (last) begin
                        match_d = 1'b0;
                        ridx_d  = '0;
                        allow_d = (priv_q == PRIV_LVL_S);
                        state_d = RESP;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            priv_q  <= PRIV_LVL_U;
            sum_q   <= 1'b0;
            match_q <= 1'b0;
            ridx_q  <= '0;
            allow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            priv_q  <= priv_d;
            sum_q   <= sum_d;
            match_q <= match_d;
            ridx_q  <= ridx_d;
            allow_q <= allow_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign busy_o       = (state_q != IDLE);
    assign resp_match_o = match_q;
    assign resp_idx_o   = ridx_q;
    assign resp_allow_o = allow_q;
endmodule

// File: doc/spmp_seq_checker.md
Name: spmp_seq_checker

Overview:
- Sequential S-mode Physical Memory Protection (SPMP) checker that shares a single spmp_entry matcher across all NR_ENTRIES entries, scanning one entry per cycle.
- Scan order is ascending index. The lowest-numbered matching entry decides the outcome.
- Sits between a low-rate requester (PTW or uncached access port) and the SPMP CSR file. It trades latency for area versus a fully parallel checker.

Parameters:
- PLEN, 56, physical address width; passed to spmp_entry.
- NR_ENTRIES, 16, number of SPMP entries; range 1..64.
- IDXW, $clog2(NR_ENTRIES) with minimum 1, width of the entry index.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  abort any in-flight check; no response is produced
- req_valid_i  in  1  check request valid
- req_ready_o  out  1  high only in IDLE
- req_addr_i  in  PLEN  physical address to check
- req_access_i  in  3  {X,W,R} one-hot access type
- priv_lvl_i  in  riscv::priv_lvl_t  privilege of the access: S or U (M is never sent)
- sum_i  in  1  sstatus.SUM
- spmpcfg_i  in  NR_ENTRIES x 8  per-entry cfg: [0]R [1]W [2]X [4:3]A (riscv::pmp_addr_mode_t) [6:5] reserved [7]U
- spmpaddr_i  in  NR_ENTRIES x riscv::spmpaddr_t  per-entry address CSRs
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  result consumed
- resp_allow_o  out  1  access permitted
- resp_match_o  out  1  some entry matched
- resp_idx_o  out  IDXW  index of the matching entry; 0 if no entry matched
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state = IDLE, idx = 0, latched request = 0. Outputs: req_ready_o = 1, resp_valid_o = 0, resp_allow_o = 0, resp_match_o = 0, resp_idx_o = 0, busy_o = 0.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - On req_valid_i & req_ready_o, latch addr, access, priv and sum; set idx = 0; go to SCAN.
- SCAN: drive the shared spmp_entry every cycle with:
  - addr = latched addr
  - spmpaddr_i[idx]
  - prev = (idx == 0) ? 0 : spmpaddr_i[idx-1]
  - mode = spmpcfg_i[idx][4:3]
- SCAN on match: register resp_match = 1, resp_idx = idx, allow = perm(cfg[idx]); go to RESP.
- SCAN with no match and idx == NR_ENTRIES-1: register resp_match = 0, resp_idx = 0, allow = (priv == S); go to RESP.
- SCAN otherwise: idx += 1. idx never wraps.
- perm(cfg) rules:
  - Base permission: the requested R/W/X bit must be set in cfg.
  - U-mode: requires cfg.U = 1.
  - S-mode with cfg.U = 0: base rule only.
  - S-mode with cfg.U = 1: X is always denied; R/W are allowed only if sum_i = 1.
- Latency: accept at edge 0; a match at index k gives resp_valid_o high after edge k+1. No match gives resp_valid_o high after edge NR_ENTRIES.
- RESP: hold all resp_* outputs stable while resp_valid_o & !resp_ready_i. On resp_ready_i, go to IDLE; req_ready_o rises the following cycle. There is no same-cycle back-to-back accept.
- Config sampling: config is read live during SCAN. Software guarantees stability via fence, so a cfg change mid-scan gives an undefined decision but never a hang.
- flush_i has priority over every transition:
  - SCAN or RESP: go to IDLE next cycle with resp_valid_o = 0.
  - IDLE: a request presented in the same cycle is not accepted.
- Reset asserted mid-operation: immediately return to the reset values; no response is produced.
- resp_* outputs are registered. They hold their last value in IDLE but are qualified only by resp_valid_o.

Test Plan:
- Entry 0 NAPOT spmpaddr = 0x1FF (base 0x0, 4 KiB), cfg = R|U. Request U-mode read 0x0800 -> resp after 1 cycle: match = 1, idx = 0, allow = 1. Same request as write -> allow = 0.
- Entries 0..2 OFF, entry 3 TOR with spmpaddr[2] = 0x400 and spmpaddr[3] = 0x800, cfg = R|W. Request S-mode write 0x1800 -> resp_valid_o after edge 4: idx = 3, allow = 1.
- All entries OFF. S-mode read 0x5000 -> after edge NR_ENTRIES (16): match = 0, allow = 1. U-mode read 0x5000 -> allow = 0.
- Overlapping entries: entry 1 NA4 at 0x100 with cfg = 0; entry 5 NAPOT covering 0x100 with cfg = R. Read 0x100 -> idx = 1, allow = 0 (lowest index wins).
- S-mode access to a cfg = R|W|X|U entry:
  - sum_i = 0, read -> deny
  - sum_i = 1, read -> allow
  - sum_i = 1, execute -> deny
- Control and handshake:
  - Assert flush_i during SCAN at idx = 2 -> no resp_valid_o; req_ready_o = 1 the next cycle.
  - Hold resp_ready_i = 0 for 5 cycles -> resp_* stable throughout.
  - Assert rst_ni low mid-SCAN -> all outputs return to reset values asynchronously.
